// File: rtl/branch_seq.sv
// Conditional-branch control sequencer: evaluates the branch condition, then
// either steps PC <= PC + sext(C) through Y/ALU/Z or finishes early.
module branch_seq #(
   parameter logic [4:0] BR_OPCODE = 5'b10010,
   parameter int         CW        = 16
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic [31:0]   ir,
   input  logic          con_result,
   output logic          Gra,
   output logic          Rout,
   output logic          CONin,
   output logic          PCout,
   output logic          Yin,
   output logic          Cout,
   output logic          add_op,
   output logic          Zin,
   output logic          Zlowout,
   output logic          PCin,
   output logic          busy,
   output logic          done,
   output logic          illegal,
   output logic [31:0]   c_sign_ext,
   output logic [CW-1:0] taken_count,
   output logic [CW-1:0] nottaken_count,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EVAL = 3'd1,
      S_WAIT = 3'd2,
      S_ADD1 = 3'd3,
      S_ADD2 = 3'd4,
      S_WB   = 3'd5,
      S_DONE = 3'd6
   } state_t;

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   state_t        state_q, state_d;
   logic [31:0]   ir_q, ir_d;
   logic          illegal_q, illegal_d;
   logic [CW-1:0] taken_q, taken_d;
   logic [CW-1:0] nottaken_q, nottaken_d;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= S_IDLE;
         ir_q       <= '0;
         illegal_q  <= 1'b0;
         taken_q    <= '0;
         nottaken_q <= '0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         illegal_q  <= illegal_d;
         taken_q    <= taken_d;
         nottaken_q <= nottaken_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      illegal_d  = illegal_q;
      taken_d    = taken_q;
      nottaken_d = nottaken_q;
      case (state_q)
         S_IDLE: begin
            illegal_d = 1'b0;
            if (start) begin
               ir_d = ir;
               if (ir[31:27] == BR_OPCODE) begin
                  state_d = S_EVAL;
               end else begin
                  state_d   = S_DONE;
                  illegal_d = 1'b1;
               end
            end
         end
         S_EVAL: state_d = S_WAIT;
         S_WAIT: begin
            // Condition flip-flop was loaded by CONin in EVAL; it is stable here.
            if (con_result) begin
               if (taken_q != CNT_MAX) taken_d = taken_q + CNT_ONE;
               state_d = S_ADD1;
            end else begin
               if (nottaken_q != CNT_MAX) nottaken_d = nottaken_q + CNT_ONE;
               state_d = S_DONE;
            end
         end
         S_ADD1: state_d = S_ADD2;
         S_ADD2: state_d = S_WB;
         S_WB:   state_d = S_DONE;
         S_DONE: begin
            state_d   = S_IDLE;
            illegal_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore decode of the state register only; inputs never reach outputs.
   assign Gra            = (state_q == S_EVAL);
   assign Rout           = (state_q == S_EVAL);
   assign CONin          = (state_q == S_EVAL);
   assign PCout          = (state_q == S_ADD1);
   assign Yin            = (state_q == S_ADD1);
   assign Cout           = (state_q == S_ADD2);
   assign add_op         = (state_q == S_ADD2);
   assign Zin            = (state_q == S_ADD2);
   assign Zlowout        = (state_q == S_WB);
   assign PCin           = (state_q == S_WB);
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign illegal        = (state_q == S_DONE) && illegal_q;
   assign c_sign_ext     = {{13{ir_q[18]}}, ir_q[18:0]};
   assign taken_count    = taken_q;
   assign nottaken_count = nottaken_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: per-cycle strobe scoreboard driven by a
// vector table, plus busy re-pulse, mid-sequence reset and saturation sequences.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        con_result = 1'b0;
  logic        Gra, Rout, CONin, PCout, Yin, Cout, add_op, Zin, Zlowout, PCin;
  logic        busy, done, illegal;
  logic [31:0] c_sign_ext;
  logic [15:0] taken_count, nottaken_count;
  logic [2:0]  state_dbg;

  logic        start2 = 1'b0;
  logic [31:0] ir2 = '0;
  logic        con2 = 1'b0;
  logic        s_gra, s_rout, s_conin, s_pcout, s_yin, s_cout, s_add, s_zin, s_zlo, s_pcin;
  logic        s_busy, s_done, s_ill;
  logic [31:0] s_sext;
  logic [1:0]  s_taken, s_nottaken;
  logic [2:0]  s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_seq #(.BR_OPCODE(5'b10010), .CW(16)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .con_result(con_result),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin),
    .Cout(Cout), .add_op(add_op), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
    .busy(busy), .done(done), .illegal(illegal), .c_sign_ext(c_sign_ext),
    .taken_count(taken_count), .nottaken_count(nottaken_count), .state_dbg(state_dbg)
  );

  branch_seq #(.BR_OPCODE(5'b10010), .CW(2)) dut_sat (
    .clk(clk), .clr(clr), .start(start2), .ir(ir2), .con_result(con2),
    .Gra(s_gra), .Rout(s_rout), .CONin(s_conin), .PCout(s_pcout), .Yin(s_yin),
    .Cout(s_cout), .add_op(s_add), .Zin(s_zin), .Zlowout(s_zlo), .PCin(s_pcin),
    .busy(s_busy), .done(s_done), .illegal(s_ill), .c_sign_ext(s_sext),
    .taken_count(s_taken), .nottaken_count(s_nottaken), .state_dbg(s_state)
  );

  // Bundle order: Gra Rout CONin PCout Yin Cout add_op Zin Zlowout PCin busy done illegal
  localparam logic [12:0] B_IDLE = 13'b0000000000000;
  localparam logic [12:0] B_EVAL = 13'b1110000000100;
  localparam logic [12:0] B_WAIT = 13'b0000000000100;
  localparam logic [12:0] B_ADD1 = 13'b0001100000100;
  localparam logic [12:0] B_ADD2 = 13'b0000011100100;
  localparam logic [12:0] B_WB   = 13'b0000000011100;
  localparam logic [12:0] B_DONE = 13'b0000000000110;
  localparam logic [12:0] B_DILL = 13'b0000000000111;

  logic [12:0] exp_q[$];

  typedef struct {
    logic [31:0] ir_v;
    logic        con_v;
    logic [31:0] exp_sext;
    logic [15:0] exp_taken;
    logic [15:0] exp_nottaken;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [12:0] bundle();
    return {Gra, Rout, CONin, PCout, Yin, Cout, add_op, Zin, Zlowout, PCin, busy, done, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Runs one transaction; repulse bit c raises start during cycle c.
  task automatic run_txn(input logic [31:0] ir_v, input logic con_v,
                         input logic [31:0] exp_sext, input logic [15:0] repulse);
    logic [12:0] e;
    logic [12:0] got;
    int          cyc;
    int          n_done;
    if (ir_v[31:27] == 5'b10010) begin
      exp_q.push_back(B_EVAL);
      exp_q.push_back(B_WAIT);
      if (con_v) begin
        exp_q.push_back(B_ADD1);
        exp_q.push_back(B_ADD2);
        exp_q.push_back(B_WB);
      end
      exp_q.push_back(B_DONE);
    end else begin
      exp_q.push_back(B_DILL);
    end
    exp_q.push_back(B_IDLE);
    start = 1'b1;
    ir = ir_v;
    con_result = con_v;
    @(posedge clk); #1;
    start = 1'b0;
    ir = 32'hFFFF_FFFF;
    cyc = 1;
    n_done = 0;
    while (exp_q.size() > 0) begin
      got = bundle();
      e = exp_q.pop_front();
      chk($sformatf("strobes_c%0d", cyc), {19'd0, got}, {19'd0, e});
      if (got[1]) n_done++;
      if (e == B_ADD2) chk("sext_in_add2", c_sign_ext, exp_sext);
      start = repulse[cyc];
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_pulses", n_done, 1);
    chk("sext_hold", c_sign_ext, exp_sext);
  endtask

  initial begin
    vecs[0] = '{32'h90000008, 1'b1, 32'h00000008, 16'd1, 16'd0};
    vecs[1] = '{32'h90080008, 1'b0, 32'h00000008, 16'd1, 16'd1};
    vecs[2] = '{32'h9007FFFC, 1'b1, 32'hFFFFFFFC, 16'd2, 16'd1};
    vecs[3] = '{32'h10000000, 1'b1, 32'h00000000, 16'd2, 16'd1};
    vecs[4] = '{32'h90040000, 1'b0, 32'hFFFC0000, 16'd2, 16'd2};
    vecs[5] = '{32'h97FFFFFF, 1'b1, 32'hFFFFFFFF, 16'd3, 16'd2};
    vecs[6] = '{32'hF8000005, 1'b0, 32'h00000005, 16'd3, 16'd2};

    // Reset state
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {19'd0, bundle()}, 32'd0);
    chk("rst_sext", c_sign_ext, 32'd0);
    chk("rst_taken", {16'd0, taken_count}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].ir_v, vecs[i].con_v, vecs[i].exp_sext, 16'h0000);
      chk($sformatf("taken_v%0d", i), {16'd0, taken_count}, {16'd0, vecs[i].exp_taken});
      chk($sformatf("nottaken_v%0d", i), {16'd0, nottaken_count}, {16'd0, vecs[i].exp_nottaken});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // start re-pulsed in cycles 2 (busy) and 6 (DONE) must be ignored
    run_txn(32'h90000010, 1'b1, 32'h00000010, 16'b0000_0000_0100_0100);
    chk("repulse_taken", {16'd0, taken_count}, 32'd4);
    chk("repulse_idle", {31'd0, busy}, 32'd0);

    // Saturation with CW=2
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_sat[5];
      bit         seen;
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      start2 = 1'b1;
      ir2 = 32'h90000008;
      con2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        if (s_done) seen = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      chk($sformatf("sat_done_%0d", k), {31'd0, seen}, 32'd1);
      chk($sformatf("sat_taken_%0d", k), {30'd0, s_taken}, {30'd0, exp_sat[k]});
      @(posedge clk); #1;
    end

    // Reset in ADD2 of a taken sequence
    start = 1'b1;
    ir = 32'h9007FFFC;
    con_result = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_clr_add2", {19'd0, bundle()}, {19'd0, B_ADD2});
    #2;
    clr = 1'b0;
    #1;
    chk("clr_strobes", {19'd0, bundle()}, 32'd0);
    chk("clr_state", {29'd0, state_dbg}, 32'd0);
    chk("clr_sext", c_sign_ext, 32'd0);
    chk("clr_taken", {16'd0, taken_count}, 32'd0);
    chk("clr_nottaken", {16'd0, nottaken_count}, 32'd0);
    chk("clr_sat_taken", {30'd0, s_taken}, 32'd0);
    @(posedge clk); #1;
    chk("clr_hold_wb", {31'd0, PCin}, 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    run_txn(32'h90000008, 1'b1, 32'h00000008, 16'h0000);
    chk("recover_taken", {16'd0, taken_count}, 32'd1);
    chk("recover_nottaken", {16'd0, nottaken_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Multi-cycle control sequencer for conditional-branch instructions in the mini CPU datapath.
- Drives the strobes that evaluate the branch condition: Ra onto the bus, CONin pulsed, so the condition flip-flop latches its result.
- Samples the returned condition flag. If the branch is taken, sequences PC <= PC + sign-extended C through the Y/ALU/Z path; otherwise finishes early.
- Keeps saturating taken/not-taken counters for debug.

Parameters:
BR_OPCODE, 5'b10010, ir[31:27] value identifying a conditional branch
CW, 16, width of the taken/not-taken counters

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
start  input  1  one-cycle request from main control; instruction in ir is to be executed
ir  input  32  instruction register contents, sampled when start is accepted
con_result  input  1  condition flag from the condition flip-flop
Gra  output  1  select Ra field for register-file read
Rout  output  1  selected register drives the bus
CONin  output  1  condition flip-flop load strobe
PCout  output  1  PC drives the bus
Yin  output  1  load Y register
Cout  output  1  c_sign_ext drives the bus
add_op  output  1  ALU performs ADD
Zin  output  1  load Z register
Zlowout  output  1  Z[31:0] drives the bus
PCin  output  1  load PC from the bus
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
illegal  output  1  one-cycle pulse, concurrent with done, when the opcode is not BR_OPCODE
c_sign_ext  output  32  ir_q[18:0] sign-extended from bit 18
taken_count  output  CW  saturating count of taken branches
nottaken_count  output  CW  saturating count of not-taken branches

Behaviour:
- Reset: clr low asynchronously forces state to IDLE.
  - All strobes, busy, done and illegal go to 0.
  - c_sign_ext, the internal ir_q and both counters go to 0.
  - Applies mid-sequence as well: the sequence is abandoned, and a partially applied PC update is not completed.
- All outputs are registered, Moore-decoded from state; no combinational path from inputs to outputs.
- States: IDLE, EVAL, WAIT, ADD1, ADD2, WB, DONE.
- IDLE:
  - start=1 latches ir into ir_q.
  - If ir[31:27]==BR_OPCODE, next state is EVAL; otherwise next is DONE with illegal set.
- EVAL (1 cycle): Gra=Rout=CONin=1.
- WAIT (1 cycle): all strobes 0. con_result is sampled at the end of this cycle.
  - 1: taken_count increments, next state ADD1.
  - 0: nottaken_count increments, next state DONE.
- ADD1: PCout=Yin=1.
- ADD2: Cout=add_op=Zin=1.
- WB: Zlowout=PCin=1.
- DONE: done=1 for exactly one cycle, then IDLE. illegal=1 in DONE only if it was set on entry.
- Latency, counting the start-sampling edge as cycle 0:
  - Taken: done in cycle 6.
  - Not taken: done in cycle 3.
  - Illegal: done in cycle 1.
- start while busy=1 is ignored: no latch, no queue. start in the DONE cycle is also ignored.
- c_sign_ext = {{13{ir_q[18]}}, ir_q[18:0]}. It updates the cycle after acceptance and holds until the next acceptance.
- Counters saturate at all-ones and never wrap.
- Exactly one state is active at any time; the strobe groups are mutually exclusive by state.

Test Plan:
- Taken branch: clr pulse, then start with ir=32'h90000008 and con_result=1 in WAIT.
  - Required: EVAL, WAIT, ADD1, ADD2, WB strobes in cycles 1-5; done in cycle 6.
  - c_sign_ext=32'h00000008, taken_count=1.
- Not taken: ir=32'h90080008 (cond 01) with con_result=0.
  - Required: done in cycle 3; PCout, Yin, Cout, Zin, PCin never asserted; nottaken_count=1.
- Negative offset: ir=32'h9007FFFC, taken.
  - Required: c_sign_ext=32'hFFFFFFFC while Cout=1 in ADD2.
- Illegal opcode: ir=32'h10000000.
  - Required: done=illegal=1 in cycle 1; no strobes; counters unchanged.
- Busy and reset: start re-pulsed in cycles 2 and 6 of a taken sequence, then clr low during ADD2 of a new sequence.
  - Required: re-pulses ignored (exactly one done).
  - On clr: all outputs 0 immediately, state IDLE, counters 0.
- Saturation: CW=2, five taken branches.
  - Required: taken_count sequence 1, 2, 3, 3, 3.
